mc_controlunit_ws: RTL

Parametrised multi-cycle MIPS control FSM: next generation of the core's control unit. Adds ANDI/ORI/SLTI, BNE, JAL and JR, a memory-ready wait-state handshake, and an illegal-instruction flag. Sits between the instruction register (opcode/funct) and the datapath muxes and enables of the multi-cycle core; a single unified memory is shared by fetch and load/store.

---
 rtl/mc_controlunit_ws.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controlunit_ws.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake, JAL/JR support
// and a one-cycle illegal-instruction flag. Outputs are decoded from the current state.
module mc_controlunit_ws #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int RA_REG      = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       BranchNe,
  output logic       PCWrite,
  output logic       ImmZeroExt,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  if (RA_REG < 0 || RA_REG > 31) begin : g_ra_range
    $error("RA_REG must be a 5-bit register index");
  end

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  logic       w_ready;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;
  logic [2:0] w_imm_alu;

  // With wait states disabled the memory is assumed to complete every access in one cycle.
  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_o = r_state;

  // NOTE: every always_comb signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = ALU_ADD;
    case (funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_imm_alu = ALU_ADD;
    case (opcode)
      OP_ANDI: w_imm_alu = ALU_AND;
      OP_ORI:  w_imm_alu = ALU_OR;
      OP_SLTI: w_imm_alu = ALU_SLT;
      default: w_imm_alu = ALU_ADD;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:                      r_state <= S_MEMADR;
            OP_RTYPE:                          r_state <= (funct == FN_JR) ? S_JR : S_EXECUTE;
            OP_BEQ, OP_BNE:                    r_state <= S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: r_state <= S_IEXEC;
            OP_J:                              r_state <= S_JUMP;
            OP_JAL:                            r_state <= S_JAL;
            default:                           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_IEXEC:    r_state <= S_IWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    Branch     = 1'b0;
    BranchNe   = 1'b0;
    PCWrite    = 1'b0;
    ImmZeroExt = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = ALU_ADD;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_ready;
        PCWrite = w_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
          OP_ORI, OP_SLTI, OP_J, OP_JAL: illegal_op = 1'b0;
          default:                       illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        mem_req  = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
        illegal_op = ~w_funct_ok;
      end
      // funct is still stable here, so a bad funct suppresses the write-back directly.
      S_ALUWB: begin
        RegWrite = w_funct_ok;
        RegDst   = 2'b01;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        PCSrc      = 2'b01;
        ALUControl = ALU_SUB;
        Branch     = (opcode == OP_BEQ);
        BranchNe   = (opcode == OP_BNE);
      end
      S_IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = w_imm_alu;
        ImmZeroExt = (opcode == OP_ANDI) || (opcode == OP_ORI);
      end
      S_IWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b00;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b11;
      end
      default: begin
        ALUSrcB = 2'b01;
      end
    endcase
    // Reset holds FETCH's mux selects but commits nothing.
    if (reset) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      BranchNe   = 1'b0;
      PCWrite    = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
